lut_cfg_loader: RTL
===================

// Module: lut_cfg_loader
// PURPOSE
//  Serial-to-parallel configuration loader placed directly upstream of the 4-input LUT cell.
//  Collects a 2**ADDR_W-bit truth table from a bit-serial input (bit 0 first) and replays it
//  into the LUT as address/data/config-enable write strobes.
//  The LUT holds entries in level-sensitive storage, so address and data are stable one cycle before and during each strobe.
// PARAMETERS
//  ADDR_W   4   LUT address width; table depth DEPTH = 2**ADDR_W (16)
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  cfg_start    in   1       1-cycle pulse: begin a new load; ignored while busy=1
//  cfg_valid    in   1       qualifies cfg_sdi; one table bit accepted per cycle with cfg_valid=1
//  cfg_sdi      in   1       serial table bit (entry 0 first)
//  lut_addr     out  ADDR_W  LUT write address
//  lut_data     out  1       LUT write data
//  lut_cfg_en   out  1       LUT config enable (write strobe)
//  busy         out  1       high from accepted cfg_start until return to IDLE
//  done         out  1       1-cycle pulse: table written successfully
//  err          out  1       sticky error flag; cleared by next accepted cfg_start
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; lut_addr=0, lut_data=0, lut_cfg_en=0,
//    busy=0, done=0, err=0. Shift register and bit counter cleared.
//  - All outputs registered. FSM: IDLE -> SHIFT -> SETUP <-> STROBE -> DONE -> IDLE.
//  - IDLE: cfg_start=1 -> SHIFT next cycle; busy=1, err=0, bit counter=0.
//  - SHIFT: each cycle with cfg_valid=1 stores cfg_sdi at shreg[cnt], cnt++; cfg_valid=0 stalls
//    (no timeout). After the last required bit -> SETUP with entry index i=0.
//  - SETUP (1 cycle): lut_addr=i, lut_data=shreg[i], lut_cfg_en=0 -> STROBE.
//  - STROBE (1 cycle): lut_cfg_en=1, addr/data unchanged. If i==DEPTH-1 -> DONE, else i++ -> SETUP.
//  - Write phase = 2*DEPTH cycles (32); lut_cfg_en never high in two consecutive cycles.
//  - DONE (1 cycle): done=1, lut_cfg_en=0, lut_addr=0, lut_data=0; busy drops entering IDLE.
//  - Latency: cfg_start -> first strobe = 1 + DEPTH(+parity) accepted bits + 1 SETUP cycle.
//  - cfg_start while busy: ignored, no effect on state, counters or err.
//  - cfg_valid outside SHIFT: ignored. Extra bits after the last are not captured.
//  - Index wrap: counter width ADDR_W+1; no wrap to 0 mid-table.
//  - Reset mid-load: write sequence aborts immediately, lut_cfg_en=0 asynchronously;
//    LUT contents already written are left as-is (partial table).
// CONFIGURATION
//  - LUT_CFG_PARITY_EN defined: SHIFT accepts DEPTH+1 bits; bit DEPTH is even parity
//    over the table (XOR of all DEPTH+1 bits must be 0). Mismatch -> err=1, no strobes,
//    straight to IDLE (done not pulsed). Match -> normal write phase.
//  - Not defined: exactly DEPTH bits accepted, no check, err stays 0 always.
// TESTING
//  1. Reset: rst_n=0 mid-SHIFT -> all outputs 0, state IDLE; next cfg_start works normally.
//  2. Load 16'hA5C3 (bit0 first) -> 16 strobes addr 0..15, lut_data on strobe k = bit k;
//     done pulses once; busy high from cycle after cfg_start through DONE.
//  3. cfg_valid toggling 1/0 during SHIFT -> only qualified bits captured; table identical to
//     continuous-valid run; strobe spacing always 2 cycles.
//  4. cfg_start pulsed during SHIFT and during STROBE -> ignored; single done; table unchanged.
//  5. rst_n=0 during STROBE at addr 7 -> lut_cfg_en drops same cycle, no further strobes.
//  6. LUT_CFG_PARITY_EN: 16'h0001 + parity 1 -> done, 16 strobes;
//     16'h0001 + parity 0 -> err=1, zero strobes, done=0; next cfg_start clears err.

Source files
------------

// File: rtl/lut_cfg_loader.sv
// Bit-serial truth-table loader that replays the table into a LUT as SETUP/STROBE writes.
// Optional even-parity trailer bit enabled by defining LUT_CFG_PARITY_EN.
module lut_cfg_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_sdi,
    output logic [ADDR_W-1:0] lut_addr,
    output logic              lut_data,
    output logic              lut_cfg_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
`ifdef LUT_CFG_PARITY_EN
    localparam int NBITS = DEPTH + 1;
`else
    localparam int NBITS = DEPTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] TBL_END = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SETUP,
        STROBE,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [ADDR_W-1:0]  idx, idx_d;
    logic [DEPTH-1:0]   shreg, shreg_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               data_d, en_d, busy_d, done_d, err_d;
    logic               par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            lut_addr   <= '0;
            lut_data   <= 1'b0;
            lut_cfg_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            shreg      <= shreg_d;
            lut_addr   <= addr_d;
            lut_data   <= data_d;
            lut_cfg_en <= en_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        addr_d  = '0;
        data_d  = 1'b0;
        en_d    = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = err;
`ifdef LUT_CFG_PARITY_EN
        par_bad = ^{shreg, cfg_sdi};
`else
        par_bad = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cfg_valid) begin
                    cnt_d = cnt + 1'b1;
                    if (cnt < TBL_END)
                        shreg_d[cnt[ADDR_W-1:0]] = cfg_sdi;
                    if (cnt == LAST) begin
                        if (par_bad) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            state_d = SETUP;
                            idx_d   = '0;
                            data_d  = shreg_d[0];
                        end
                    end
                end
            end
            SETUP: begin
                // Address/data were presented on entry; hold them under the strobe.
                state_d = STROBE;
                addr_d  = lut_addr;
                data_d  = lut_data;
                en_d    = 1'b1;
            end
            STROBE: begin
                if (idx == '1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = SETUP;
                    addr_d  = idx_d;
                    data_d  = shreg[idx_d];
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
